// File: rtl/masked_share_loader.sv
// Masked share loader: accepts LOAD/REFRESH commands, fetches non-zero PRNG masks and issues
// exactly one register-file write per accepted command. Secrets are wiped after every operation.
module masked_share_loader #(
  parameter int unsigned MAX_RETRY = 4,
  parameter int unsigned RF_DEPTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic        op_i,
  input  logic [3:0]  dst_addr_i,
  input  logic [3:0]  src_addr_i,
  input  logic [63:0] data_i,
  output logic        rnd_req_o,
  input  logic        rnd_ack_i,
  input  logic [63:0] rnd_i,
  output logic [3:0]  rf_addr_o,
  output logic [63:0] rf_input0_o,
  output logic [63:0] rf_input1_o,
  output logic [63:0] rf_input2_o,
  output logic        rf_random_o,
  output logic        rf_write_en_o,
  output logic        done_o,
  output logic        err_o
);

  // Highest legal base addresses: a LOAD pair spans dst..dst+1, a REFRESH spans dst..dst+3,
  // and the REFRESH source pair spans src..src+1.
  localparam logic [3:0] LoadDstMax = 4'(RF_DEPTH - 2);
  localparam logic [3:0] RefDstMax  = 4'(RF_DEPTH - 4);
  localparam logic [3:0] RefSrcMax  = 4'(RF_DEPTH - 2);
  localparam logic [3:0] RetryLast  = 4'(MAX_RETRY - 1);

  localparam logic OpLoad    = 1'b0;
  localparam logic OpRefresh = 1'b1;

  typedef enum logic [1:0] {StIdle, StFetchR1, StFetchR2, StWrite} state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [3:0]  dst_q, dst_d;
  logic [3:0]  src_q, src_d;
  logic [63:0] data_q, data_d;
  logic [63:0] r1_q, r1_d;
  logic [63:0] r2_q, r2_d;
  logic [3:0]  retry_q, retry_d;
  logic        err_q, err_d;

  logic accept, cmd_ok, fetch, rnd_zero, rnd_take, rnd_abort;

  assign accept    = op_valid_i && (state_q == StIdle);
  assign cmd_ok    = (op_i == OpRefresh) ? ((dst_addr_i <= RefDstMax) && (src_addr_i <= RefSrcMax))
                                         : (dst_addr_i <= LoadDstMax);
  assign fetch     = (state_q == StFetchR1) || (state_q == StFetchR2);
  assign rnd_zero  = (rnd_i == '0);
  assign rnd_take  = fetch && rnd_ack_i && !rnd_zero;
  assign rnd_abort = fetch && rnd_ack_i && rnd_zero && (retry_q == RetryLast);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && cmd_ok) state_d = StFetchR1;
      end
      StFetchR1: begin
        if (rnd_take)       state_d = (op_q == OpRefresh) ? StFetchR2 : StWrite;
        else if (rnd_abort) state_d = StIdle;
      end
      StFetchR2: begin
        if (rnd_take)       state_d = StWrite;
        else if (rnd_abort) state_d = StIdle;
      end
      StWrite: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= OpLoad;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      data_q  <= data_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  // Datapath next-state: capture on accept, collect masks, wipe secrets on exit or abort.
  always_comb begin
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    data_d  = data_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    retry_d = retry_q;
    err_d   = 1'b0;

    if (accept) begin
      if (cmd_ok) begin
        op_d    = op_i;
        dst_d   = dst_addr_i;
        src_d   = src_addr_i;
        data_d  = (op_i == OpLoad) ? data_i : '0;
        retry_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (fetch && rnd_ack_i) begin
      if (!rnd_zero) begin
        if (state_q == StFetchR1) r1_d = rnd_i;
        else                      r2_d = rnd_i;
        retry_d = '0;
      end else if (rnd_abort) begin
        err_d   = 1'b1;
        data_d  = '0;
        r1_d    = '0;
        r2_d    = '0;
        retry_d = '0;
      end else begin
        retry_d = retry_q + 4'd1;
      end
    end

    if (state_q == StWrite) begin
      data_d = '0;
      r1_d   = '0;
      r2_d   = '0;
    end
  end

  // Outputs: rf_* are only non-zero during the single WRITE cycle.
  always_comb begin
    op_ready_o    = (state_q == StIdle);
    rnd_req_o     = fetch;
    err_o         = err_q;
    done_o        = 1'b0;
    rf_write_en_o = 1'b0;
    rf_addr_o     = '0;
    rf_input0_o   = '0;
    rf_input1_o   = '0;
    rf_input2_o   = '0;
    rf_random_o   = 1'b0;
    if (state_q == StWrite) begin
      done_o        = 1'b1;
      rf_write_en_o = 1'b1;
      rf_addr_o     = dst_q;
      rf_input1_o   = r1_q;
      if (op_q == OpRefresh) begin
        rf_input0_o = {60'b0, src_q};
        rf_input2_o = r2_q;
        rf_random_o = 1'b1;
      end else begin
        rf_input0_o = data_q ^ r1_q;
      end
    end
  end

endmodule

// File: tb/tb_masked_share_loader.sv
// Directed bench for masked_share_loader with a write scoreboard checked every cycle.
module tb_masked_share_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        op_valid_i;
  logic        op_ready_o;
  logic        op_i;
  logic [3:0]  dst_addr_i;
  logic [3:0]  src_addr_i;
  logic [63:0] data_i;
  logic        rnd_req_o;
  logic        rnd_ack_i;
  logic [63:0] rnd_i;
  logic [3:0]  rf_addr_o;
  logic [63:0] rf_input0_o;
  logic [63:0] rf_input1_o;
  logic [63:0] rf_input2_o;
  logic        rf_random_o;
  logic        rf_write_en_o;
  logic        done_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  masked_share_loader #(
    .MAX_RETRY (4),
    .RF_DEPTH  (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .op_valid_i    (op_valid_i),
    .op_ready_o    (op_ready_o),
    .op_i          (op_i),
    .dst_addr_i    (dst_addr_i),
    .src_addr_i    (src_addr_i),
    .data_i        (data_i),
    .rnd_req_o     (rnd_req_o),
    .rnd_ack_i     (rnd_ack_i),
    .rnd_i         (rnd_i),
    .rf_addr_o     (rf_addr_o),
    .rf_input0_o   (rf_input0_o),
    .rf_input1_o   (rf_input1_o),
    .rf_input2_o   (rf_input2_o),
    .rf_random_o   (rf_random_o),
    .rf_write_en_o (rf_write_en_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [63:0] in0;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        random;
  } wr_t;

  wr_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and pop/compare any RF write the DUT is presenting.
  task automatic tick();
    wr_t e;
    @(negedge clk_i);
    if (rf_write_en_o === 1'b1) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_spurious: observed write to addr %0d expected no write", rf_addr_o);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr",   64'(rf_addr_o),   64'(e.addr));
        chk("wr_input0", rf_input0_o,      e.in0);
        chk("wr_input1", rf_input1_o,      e.in1);
        chk("wr_input2", rf_input2_o,      e.in2);
        chk("wr_random", 64'(rf_random_o), 64'(e.random));
      end
    end
  endtask

  // Present a command for one cycle; returns in the cycle after the accept edge.
  task automatic issue(input logic op, input logic [3:0] dst, input logic [3:0] src,
                       input logic [63:0] data);
    op_valid_i = 1'b1;
    op_i       = op;
    dst_addr_i = dst;
    src_addr_i = src;
    data_i     = data;
    tick();
    op_valid_i = 1'b0;
    data_i     = '0;
  endtask

  // Ack one PRNG word for one cycle.
  task automatic feed(input logic [63:0] word);
    rnd_ack_i = 1'b1;
    rnd_i     = word;
    tick();
    rnd_ack_i = 1'b0;
    rnd_i     = '0;
  endtask

  function automatic wr_t exp_load(input logic [3:0] dst, input logic [63:0] d,
                                   input logic [63:0] r);
    wr_t e;
    e.addr = dst; e.in0 = d ^ r; e.in1 = r; e.in2 = '0; e.random = 1'b0;
    return e;
  endfunction

  function automatic wr_t exp_refresh(input logic [3:0] dst, input logic [3:0] src,
                                      input logic [63:0] r1, input logic [63:0] r2);
    wr_t e;
    e.addr = dst; e.in0 = {60'b0, src}; e.in1 = r1; e.in2 = r2; e.random = 1'b1;
    return e;
  endfunction

  initial begin
    rst_ni     = 1'b0;
    op_valid_i = 1'b0;
    op_i       = 1'b0;
    dst_addr_i = '0;
    src_addr_i = '0;
    data_i     = '0;
    rnd_ack_i  = 1'b0;
    rnd_i      = '0;

    // Reset values
    tick();
    chk("rst_ready",  64'(op_ready_o),    64'd1);
    chk("rst_rndreq", 64'(rnd_req_o),     64'd0);
    chk("rst_wen",    64'(rf_write_en_o), 64'd0);
    chk("rst_done",   64'(done_o),        64'd0);
    chk("rst_err",    64'(err_o),         64'd0);
    chk("rst_in0",    rf_input0_o,        64'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // LOAD, ack on first request: write two cycles after accept
    sb.push_back(exp_load(4'd4, 64'hDEADBEEF_00000001, 64'h0F0F0F0F_0F0F0F0F));
    issue(1'b0, 4'd4, 4'd0, 64'hDEADBEEF_00000001);
    chk("ld_rndreq", 64'(rnd_req_o),  64'd1);
    chk("ld_busy",   64'(op_ready_o), 64'd0);
    feed(64'h0F0F0F0F_0F0F0F0F);
    chk("ld_wen",   64'(rf_write_en_o), 64'd1);
    chk("ld_done",  64'(done_o),        64'd1);
    chk("ld_in0_k", rf_input0_o,        64'hD1A2B1E0_0F0F0F0E);
    tick();
    chk("ld_post_wen",  64'(rf_write_en_o), 64'd0);
    chk("ld_post_in0",  rf_input0_o,        64'd0);
    chk("ld_post_in1",  rf_input1_o,        64'd0);
    chk("ld_post_done", 64'(done_o),        64'd0);
    chk("ld_post_rdy",  64'(op_ready_o),    64'd1);

    // REFRESH: write three cycles after accept
    sb.push_back(exp_refresh(4'd8, 4'd4, 64'h11, 64'h22));
    issue(1'b1, 4'd8, 4'd4, 64'd0);
    feed(64'h11);
    chk("rf_r2_req",  64'(rnd_req_o), 64'd1);
    chk("rf_r2_done", 64'(done_o),    64'd0);
    feed(64'h22);
    chk("rf_done", 64'(done_o), 64'd1);
    tick();

    // LOAD with three zero words then a good one: done at accept+5, no error
    sb.push_back(exp_load(4'd2, 64'h01234567_89ABCDEF, 64'h5));
    issue(1'b0, 4'd2, 4'd0, 64'h01234567_89ABCDEF);
    feed(64'd0);
    feed(64'd0);
    feed(64'd0);
    chk("z3_err",    64'(err_o),  64'd0);
    chk("z3_notyet", 64'(done_o), 64'd0);
    feed(64'h5);
    chk("z3_done", 64'(done_o), 64'd1);
    tick();
    chk("z3_err_after", 64'(err_o), 64'd0);

    // LOAD with MAX_RETRY zero words: abort
    issue(1'b0, 4'd3, 4'd0, 64'hCAFEF00D_CAFEF00D);
    feed(64'd0);
    feed(64'd0);
    feed(64'd0);
    chk("z4_pre_err", 64'(err_o),     64'd0);
    chk("z4_pre_req", 64'(rnd_req_o), 64'd1);
    feed(64'd0);
    chk("z4_err",    64'(err_o),         64'd1);
    chk("z4_wen",    64'(rf_write_en_o), 64'd0);
    chk("z4_ready",  64'(op_ready_o),    64'd1);
    chk("z4_rndreq", 64'(rnd_req_o),     64'd0);
    tick();
    chk("z4_err_pulse", 64'(err_o), 64'd0);

    // LOAD dst=15 rejected; a stray ack while idle is ignored
    issue(1'b0, 4'd15, 4'd0, 64'h1);
    chk("ld15_err",    64'(err_o),      64'd1);
    chk("ld15_rndreq", 64'(rnd_req_o),  64'd0);
    chk("ld15_ready",  64'(op_ready_o), 64'd1);
    feed(64'h77);
    chk("ld15_err_pulse", 64'(err_o),     64'd0);
    chk("ld15_rndreq2",   64'(rnd_req_o), 64'd0);
    tick();

    // REFRESH dst=12, src=14: highest legal addresses
    sb.push_back(exp_refresh(4'd12, 4'd14, 64'h33, 64'h44));
    issue(1'b1, 4'd12, 4'd14, 64'd0);
    chk("rf12_err", 64'(err_o), 64'd0);
    feed(64'h33);
    feed(64'h44);
    chk("rf12_done", 64'(done_o), 64'd1);
    tick();

    // REFRESH dst=13 and src=15 rejected
    issue(1'b1, 4'd13, 4'd0, 64'd0);
    chk("rf13_err",    64'(err_o),     64'd1);
    chk("rf13_rndreq", 64'(rnd_req_o), 64'd0);
    tick();
    issue(1'b1, 4'd0, 4'd15, 64'd0);
    chk("src15_err",    64'(err_o),     64'd1);
    chk("src15_rndreq", 64'(rnd_req_o), 64'd0);
    tick();

    // Asynchronous reset while in FETCH_R2
    issue(1'b1, 4'd0, 4'd2, 64'd0);
    feed(64'h55);
    chk("mid_r2_req", 64'(rnd_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_req",   64'(rnd_req_o),     64'd0);
    chk("mid_rst_ready", 64'(op_ready_o),    64'd1);
    chk("mid_rst_wen",   64'(rf_write_en_o), 64'd0);
    chk("mid_rst_done",  64'(done_o),        64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_ready", 64'(op_ready_o), 64'd1);

    // LOAD after reset completes normally
    sb.push_back(exp_load(4'd6, 64'hA5A5A5A5_5A5A5A5A, 64'h12345678_9ABCDEF0));
    issue(1'b0, 4'd6, 4'd0, 64'hA5A5A5A5_5A5A5A5A);
    feed(64'h12345678_9ABCDEF0);
    chk("post_ld_done", 64'(done_o), 64'd1);
    tick();
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
